// File: rtl/if_npc.sv
`default_nettype none
// ============================================================================
// Module      : if_npc
// Description : Fetch-stage next-PC generator. Sequences BOOT/RUN/REFILL,
//               accepts EX-stage redirects and raises the pipeline flushes.
//               Optional macro IF_NPC_STATS_EN adds redirect and stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module if_npc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        EX_valid,
    input  logic [31:0] EX_PC,
    input  logic [31:0] EX_immout,
    input  logic [31:0] EX_aluout,
    input  logic [2:0]  EX_NPCSel,
    output logic [31:0] IF_PC,
    output logic        IF_valid,
    output logic        redirect,
    output logic        flush_ID,
    output logic        flush_EX,
    output logic        misalign
`ifdef IF_NPC_STATS_EN
    ,
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    localparam logic [31:0] c_PC_STEP   = 32'd4;
    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] c_JALR_MASK = 32'hFFFF_FFFE;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_misalign;
    logic        w_misalign_nxt;
    logic        w_redirect;
    logic [31:0] w_sum;
    logic [31:0] w_target;

    // JAL and branch share the PC-relative adder; JALR takes precedence.
    assign w_sum    = EX_PC + EX_immout;
    assign w_target = EX_NPCSel[2] ? (EX_aluout & c_JALR_MASK) : w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_misalign_nxt = 1'b0;
        w_redirect     = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
                w_pc_nxt    = RESET_PC;
            end
            S_RUN: begin
                if (EX_valid && (EX_NPCSel != 3'b000)) begin
                    w_redirect     = 1'b1;
                    w_state_nxt    = S_REFILL;
                    w_pc_nxt       = w_target & c_WORD_MASK;
                    w_misalign_nxt = w_target[1];
                end else if (!stall) begin
                    w_pc_nxt = r_pc + c_PC_STEP;
                end
            end
            S_REFILL: begin
                // EX holds the slot flushed by the redirect, so its request is stale.
                w_state_nxt = S_RUN;
                if (!stall) begin
                    w_pc_nxt = r_pc + c_PC_STEP;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
                w_pc_nxt    = RESET_PC;
            end
        endcase
    end

    assign IF_PC    = r_pc;
    assign IF_valid = (r_state != S_BOOT);
    assign redirect = w_redirect;
    assign flush_ID = w_redirect;
    assign flush_EX = w_redirect;
    assign misalign = r_misalign;

`ifdef IF_NPC_STATS_EN
    logic [31:0] r_redirect_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_cnt <= 32'd0;
            r_stall_cnt    <= 32'd0;
        end else begin
            if (w_redirect) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
            if (stall && !w_redirect && (r_state != S_BOOT)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign redirect_cnt = r_redirect_cnt;
    assign stall_cnt    = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_npc.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_npc
// Description : Directed self-checking bench for if_npc (RESET_PC = 0x3000).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_npc;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_alu;
    logic [2:0]  ex_sel;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        redirect;
    logic        flush_id;
    logic        flush_ex;
    logic        misalign;
`ifdef IF_NPC_STATS_EN
    logic [31:0] redirect_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    if_npc #(
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .EX_valid  (ex_valid),
        .EX_PC     (ex_pc),
        .EX_immout (ex_imm),
        .EX_aluout (ex_alu),
        .EX_NPCSel (ex_sel),
        .IF_PC     (if_pc),
        .IF_valid  (if_valid),
        .redirect  (redirect),
        .flush_ID  (flush_id),
        .flush_EX  (flush_ex),
        .misalign  (misalign)
`ifdef IF_NPC_STATS_EN
        ,
        .redirect_cnt (redirect_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; ex_valid = 1'b1; ex_sel = 3'b001;
        ex_pc = 32'h0; ex_imm = 32'h0; ex_alu = 32'h0;

        // Reset: a pending redirect request must not leak through.
        tick();
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0000_3000);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_flush_id", {31'd0, flush_id}, 32'd0);
        chk("rst_flush_ex", {31'd0, flush_ex}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        tick();
        chk("rst_hold_valid", {31'd0, if_valid}, 32'd0);

        // BOOT cycle, then sequential fetch
        rst = 1'b0; ex_valid = 1'b0; ex_sel = 3'b000;
        #1;
        chk("boot_valid", {31'd0, if_valid}, 32'd0);
        chk("boot_pc", if_pc, 32'h0000_3000);
        tick();
        chk("run0_valid", {31'd0, if_valid}, 32'd1);
        chk("run0_pc", if_pc, 32'h0000_3000);
        tick();
        chk("run1_pc", if_pc, 32'h0000_3004);
        tick();
        chk("run2_pc", if_pc, 32'h0000_3008);

        // Backward branch: 0x40 + 0xFFFF_FFF0 = 0x30
        ex_valid = 1'b1; ex_sel = 3'b001; ex_pc = 32'h40; ex_imm = 32'hFFFF_FFF0;
        #1;
        chk("br_redirect", {31'd0, redirect}, 32'd1);
        chk("br_flush_id", {31'd0, flush_id}, 32'd1);
        chk("br_flush_ex", {31'd0, flush_ex}, 32'd1);
        tick();
        chk("br_pc", if_pc, 32'h0000_0030);
        chk("br_refill_redirect", {31'd0, redirect}, 32'd0);
        chk("br_refill_flush_ex", {31'd0, flush_ex}, 32'd0);
        chk("br_misalign", {31'd0, misalign}, 32'd0);
        chk("br_refill_valid", {31'd0, if_valid}, 32'd1);
        ex_valid = 1'b0; ex_sel = 3'b000;
        tick();
        chk("br_after_pc", if_pc, 32'h0000_0034);

        // JALR request without EX_valid is a bubble
        ex_sel = 3'b100; ex_alu = 32'h5000;
        #1;
        chk("novalid_redirect", {31'd0, redirect}, 32'd0);
        tick();
        chk("novalid_pc", if_pc, 32'h0000_0038);

        // All select bits: JALR wins, bit0 cleared
        ex_valid = 1'b1; ex_sel = 3'b111; ex_alu = 32'h1235; ex_pc = 32'h40; ex_imm = 32'h10;
        #1;
        chk("jalr_redirect", {31'd0, redirect}, 32'd1);
        tick();
        chk("jalr_pc", if_pc, 32'h0000_1234);
        chk("jalr_misalign", {31'd0, misalign}, 32'd0);
        ex_valid = 1'b0; ex_sel = 3'b000;
        tick();
        chk("jalr_after_pc", if_pc, 32'h0000_1238);

        // Stall three cycles; JAL on the second overrides the stall
        stall = 1'b1;
        #1;
        chk("stall1_redirect", {31'd0, redirect}, 32'd0);
        tick();
        chk("stall1_pc", if_pc, 32'h0000_1238);
        ex_valid = 1'b1; ex_sel = 3'b010; ex_pc = 32'h100; ex_imm = 32'h22;
        #1;
        chk("jal_redirect", {31'd0, redirect}, 32'd1);
        tick();
        chk("jal_pc", if_pc, 32'h0000_0120);
        chk("jal_misalign", {31'd0, misalign}, 32'd1);
        chk("jal_refill_redirect", {31'd0, redirect}, 32'd0);
        tick();
        chk("stall3_pc", if_pc, 32'h0000_0120);
        chk("misalign_pulse_end", {31'd0, misalign}, 32'd0);
        stall = 1'b0; ex_valid = 1'b0; ex_sel = 3'b000;
        tick();
        chk("unstall_pc", if_pc, 32'h0000_0124);

        // Adder wrap to 0xFFFF_FFFC, then PC+4 wraps to 0
        ex_valid = 1'b1; ex_sel = 3'b001; ex_pc = 32'hFFFF_FFFF; ex_imm = 32'hFFFF_FFFD;
        #1;
        chk("wrap_redirect", {31'd0, redirect}, 32'd1);
        tick();
        chk("wrap_target_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_misalign", {31'd0, misalign}, 32'd0);
        ex_valid = 1'b0; ex_sel = 3'b000;
        tick();
        chk("wrap_pc", if_pc, 32'h0000_0000);

        // Reset beats a misaligned redirect and stall in RUN
        rst = 1'b1; stall = 1'b1; ex_valid = 1'b1; ex_sel = 3'b010; ex_pc = 32'h0; ex_imm = 32'h6;
        tick();
        chk("rstrun_pc", if_pc, 32'h0000_3000);
        chk("rstrun_misalign", {31'd0, misalign}, 32'd0);
        chk("rstrun_valid", {31'd0, if_valid}, 32'd0);
        chk("rstrun_redirect", {31'd0, redirect}, 32'd0);
        rst = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_sel = 3'b000;
        tick();
        chk("rstrun_boot_exit_pc", if_pc, 32'h0000_3000);

        // Reset in REFILL with a redirect still presented
        ex_valid = 1'b1; ex_sel = 3'b001; ex_pc = 32'h200; ex_imm = 32'h8;
        #1;
        chk("rf_redirect", {31'd0, redirect}, 32'd1);
        tick();
        chk("rf_pc", if_pc, 32'h0000_0208);
`ifdef IF_NPC_STATS_EN
        chk("rf_redirect_cnt", redirect_cnt, 32'd1);
`endif
        rst = 1'b1;
        tick();
        chk("rf_rst_pc", if_pc, 32'h0000_3000);
        chk("rf_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rf_rst_flush_ex", {31'd0, flush_ex}, 32'd0);
`ifdef IF_NPC_STATS_EN
        chk("rf_rst_redirect_cnt", redirect_cnt, 32'd0);
        chk("rf_rst_stall_cnt", stall_cnt, 32'd0);
`endif
        rst = 1'b0; ex_valid = 1'b0; ex_sel = 3'b000;
        tick();
        chk("rf_run_valid", {31'd0, if_valid}, 32'd1);
        chk("rf_run_pc", if_pc, 32'h0000_3000);
        stall = 1'b1;
        tick();
        chk("final_stall_pc", if_pc, 32'h0000_3000);
`ifdef IF_NPC_STATS_EN
        chk("final_stall_cnt", stall_cnt, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
